// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: ALU operation codes,
// opcode map used by the decoder, and the sequencer state encoding.
package alu_ctrl_pkg;

    // ALU operation codes (zero-extended to ALUOP_W at the point of use)
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_LOG = 3'd2;
    localparam logic [2:0] ALU_SPC = 3'd3;
    localparam logic [2:0] ALU_MC  = 3'd4;

    // Opcode map; ranges are inclusive
    localparam int OPC_ADD_A  = 0;
    localparam int OPC_ADD_B  = 4;
    localparam int OPC_SUB_A  = 1;
    localparam int OPC_SUB_LO = 5;
    localparam int OPC_SUB_HI = 9;
    localparam int OPC_SPC    = 2;
    localparam int OPC_LOG_A  = 3;
    localparam int OPC_LOG_LO = 10;
    localparam int OPC_LOG_HI = 12;
    localparam int OPC_MC_DEF = 13;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: OP -> {ALU code, legal}.
// Kept standalone so a dual-issue front end can instantiate two copies.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int ALUOP_W   = 3,
    parameter int MC_OPCODE = OPC_MC_DEF
) (
    input  logic [OP_W-1:0]    op,
    output logic [ALUOP_W-1:0] code,
    output logic               legal
);

    logic [31:0] v;

    // Table lookup; the multi-cycle opcode is checked first so it wins any overlap
    always_comb begin
        v     = 32'(op);
        code  = ALUOP_W'(ALU_ADD);
        legal = 1'b1;
        if (v == MC_OPCODE)
            code = ALUOP_W'(ALU_MC);
        else if (v == OPC_ADD_A || v == OPC_ADD_B)
            code = ALUOP_W'(ALU_ADD);
        else if (v == OPC_SUB_A || (v >= OPC_SUB_LO && v <= OPC_SUB_HI))
            code = ALUOP_W'(ALU_SUB);
        else if (v == OPC_LOG_A || (v >= OPC_LOG_LO && v <= OPC_LOG_HI))
            code = ALUOP_W'(ALU_LOG);
        else if (v == OPC_SPC)
            code = ALUOP_W'(ALU_SPC);
        else
            legal = 1'b0;
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ID/EX ALU control stage: registered decode, stall/flush bubbles and
// sequencing of the single multi-cycle opcode (holds ALU_MC, raises busy).
// Optional: define ALU_CTRL_ILLEGAL_OP_EN to add the illegal_op output and
// turn unknown opcodes into bubbles instead of ADD issues.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int ALUOP_W   = 3,
    parameter int MC_OPCODE = OPC_MC_DEF,
    parameter int MC_LAT    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    OP,
    input  logic               valid_in,
    input  logic               stall,
    input  logic               flush,
    output logic [ALUOP_W-1:0] ALU_OP,
    output logic               valid_out,
    output logic               busy,
    output logic               stall_req
`ifdef ALU_CTRL_ILLEGAL_OP_EN
    ,
    output logic               illegal_op
`endif
);

    // Counter only needs to hold MC_LAT-1
    localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ALUOP_W-1:0] alu_op_n;
    logic               valid_n;
    logic               ill_n;
    logic [ALUOP_W-1:0] dec_code;
    logic               dec_legal;
    logic               mc_issue;

    alu_ctrl_decode #(
        .OP_W      (OP_W),
        .ALUOP_W   (ALUOP_W),
        .MC_OPCODE (MC_OPCODE)
    ) u_decode (
        .op    (OP),
        .code  (dec_code),
        .legal (dec_legal)
    );

    assign mc_issue  = dec_legal && (dec_code == ALUOP_W'(ALU_MC));
    assign busy      = (state == BUSY);
    assign stall_req = busy;

    // Next-state and next-output logic; every target defaults first
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        alu_op_n = '0;
        valid_n  = 1'b0;
        ill_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !stall && valid_in) begin
`ifdef ALU_CTRL_ILLEGAL_OP_EN
                    if (!dec_legal) begin
                        ill_n = 1'b1;
                    end else begin
                        alu_op_n = dec_code;
                        valid_n  = 1'b1;
                    end
`else
                    alu_op_n = dec_code;
                    valid_n  = 1'b1;
`endif
                    if (mc_issue && (MC_LAT > 1)) begin
                        state_n = BUSY;
                        cnt_n   = CNT_W'(MC_LAT - 1);
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    // stall does not pause the countdown
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_n = IDLE;
                    else
                        alu_op_n = ALUOP_W'(ALU_MC);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ALU_OP    <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ALU_OP    <= alu_op_n;
            valid_out <= valid_n;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_OP_EN
    // One-cycle illegal-opcode flag
    always_ff @(posedge clk) begin
        if (reset) illegal_op <= 1'b0;
        else       illegal_op <= ill_n;
    end
`else
    // Flag has no consumer when the feature is off
    logic ill_unused;
    assign ill_unused = ill_n;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: two instances (MC_LAT=4 and 1)
// share stimulus and are compared every cycle against a cycle-count model.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset, valid_in, stall, flush;
    logic [5:0] OP;
    logic [2:0] alu_op [2];
    logic       valid_out [2];
    logic       busy [2];
    logic       stall_req [2];
    logic       illegal_op [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.OP_W(6), .ALUOP_W(3), .MC_OPCODE(13), .MC_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .OP(OP), .valid_in(valid_in), .stall(stall),
        .flush(flush), .ALU_OP(alu_op[0]), .valid_out(valid_out[0]),
        .busy(busy[0]), .stall_req(stall_req[0])
`ifdef ALU_CTRL_ILLEGAL_OP_EN
        , .illegal_op(illegal_op[0])
`endif
    );

    alu_ctrl_seq #(.OP_W(6), .ALUOP_W(3), .MC_OPCODE(13), .MC_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .OP(OP), .valid_in(valid_in), .stall(stall),
        .flush(flush), .ALU_OP(alu_op[1]), .valid_out(valid_out[1]),
        .busy(busy[1]), .stall_req(stall_req[1])
`ifdef ALU_CTRL_ILLEGAL_OP_EN
        , .illegal_op(illegal_op[1])
`endif
    );

`ifndef ALU_CTRL_ILLEGAL_OP_EN
    initial begin
        illegal_op[0] = 1'b0;
        illegal_op[1] = 1'b0;
    end
`endif

    // Reference model: remaining busy cycles plus expected outputs
    typedef struct {
        int busy_left;
        int op;
        bit vld;
        bit ill;
    } mdl_t;

    mdl_t m [2];
    int   lat [2];

    // Decode table as written in the opcode map; -1 marks unknown opcodes
    function automatic int ref_dec(input int op);
        case (op) inside
            0, 4:           return 0;
            1, [5:9]:       return 1;
            3, [10:12]:     return 2;
            2:              return 3;
            13:             return 4;
            default:        return -1;
        endcase
    endfunction

    function automatic mdl_t ref_next(input mdl_t c, input int l, input bit r,
                                      input bit fl, input bit st, input bit vi,
                                      input int op);
        mdl_t n;
        int   d;
        n     = c;
        n.vld = 1'b0;
        n.ill = 1'b0;
        if (r) begin
            n.busy_left = 0;
            n.op        = 0;
        end else if (c.busy_left > 0) begin
            if (fl) begin
                n.busy_left = 0;
                n.op        = 0;
            end else begin
                n.busy_left = c.busy_left - 1;
                n.op        = (n.busy_left > 0) ? 4 : 0;
            end
        end else begin
            n.op = 0;
            if (!fl && !st && vi) begin
                d = ref_dec(op);
                if (d < 0) begin
`ifdef ALU_CTRL_ILLEGAL_OP_EN
                    n.ill = 1'b1;
`else
                    n.vld = 1'b1;
`endif
                end else begin
                    n.op  = d;
                    n.vld = 1'b1;
                    if (d == 4) n.busy_left = l - 1;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, check both instances
    task automatic step(input bit r, input bit fl, input bit st, input bit vi, input int op);
        reset    = r;
        flush    = fl;
        stall    = st;
        valid_in = vi;
        OP       = 6'(op);
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            m[k] = ref_next(m[k], lat[k], r, fl, st, vi, op);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("alu_op[%0d]", k),    32'(alu_op[k]),    32'(m[k].op));
            chk($sformatf("valid_out[%0d]", k), 32'(valid_out[k]), 32'(m[k].vld));
            chk($sformatf("busy[%0d]", k),      32'(busy[k]),      32'(m[k].busy_left > 0));
            chk($sformatf("stall_req[%0d]", k), 32'(stall_req[k]), 32'(m[k].busy_left > 0));
`ifdef ALU_CTRL_ILLEGAL_OP_EN
            chk($sformatf("illegal_op[%0d]", k), 32'(illegal_op[k]), 32'(m[k].ill));
`endif
        end
    endtask

    initial begin
        lat[0] = 4;
        lat[1] = 1;
        for (int k = 0; k < 2; k++) m[k] = '{busy_left: 0, op: 0, vld: 1'b0, ill: 1'b0};
        reset = 1'b1; flush = 1'b0; stall = 1'b0; valid_in = 1'b0; OP = '0;

        // Reset held with a live instruction on the inputs
        step(1, 0, 0, 1, 5);
        step(1, 0, 0, 1, 5);
        step(0, 0, 0, 1, 5);
        chk("first_issue_sub", 32'(alu_op[0]), 32'd1);

        // Decode sweep including an opcode outside the table
        for (int op = 0; op <= 12; op++) step(0, 0, 0, 1, op);
        step(0, 0, 0, 1, 20);
        step(0, 0, 0, 0, 0);

        // Stall bubble then release
        step(0, 0, 1, 1, 7);
        step(0, 0, 0, 1, 7);
        chk("stall_release_sub", 32'(alu_op[0]), 32'd1);

        // Multi-cycle op with stall raised while busy
        step(0, 0, 0, 1, 13);
        chk("mc_issue_code", 32'(alu_op[0]), 32'd4);
        step(0, 0, 1, 1, 3);
        step(0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("mc_done_idle", 32'(busy[0]), 32'd0);

        // Flush on the second busy cycle, then a normal issue
        step(0, 0, 0, 1, 13);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("flush_abort_busy", 32'(busy[0]), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("post_flush_sub", 32'(alu_op[0]), 32'd1);

        // Back-to-back multi-cycle ops with valid_in held high
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 13);
        step(0, 0, 0, 0, 0);

        // Randomized traffic, mostly near the interesting opcodes
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 3) == 0) ? 13 :
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 63))
                                             : int'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
